// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | shift-subtract iterations (a zero divisor finishes here after a single cycle)
// DONE  | one-cycle done pulse; start is accepted here as in IDLE
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_restoring_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             finish;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CNT_W-1:0] cnt;
  logic             dz_pend;

  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             dz_reg;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             ge;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (dz_pend || (cnt == CNT_W'(1))) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step, computed at WIDTH+1 bits so the compare never overflows.
  always_comb begin
    r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    ge      = (r_shift >= {1'b0, d_reg});
    r_step  = ge ? (r_shift - {1'b0, d_reg}) : r_shift;
    q_step  = {q_reg[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg    <= '0;
      d_reg    <= '0;
      r_reg    <= '0;
      cnt      <= '0;
      dz_pend  <= 1'b0;
      quot_reg <= '0;
      rem_reg  <= '0;
      dz_reg   <= 1'b0;
    end else if (accept) begin
      q_reg   <= bus.dividend;
      d_reg   <= bus.divisor;
      r_reg   <= '0;
      cnt     <= CNT_W'(WIDTH);
      dz_pend <= (bus.divisor == '0);
    end else if (state == CALC) begin
      if (dz_pend) begin
        // Q still holds the untouched dividend, which is the defined remainder.
        quot_reg <= '1;
        rem_reg  <= q_reg;
        dz_reg   <= 1'b1;
        dz_pend  <= 1'b0;
      end else begin
        q_reg <= q_step;
        r_reg <= r_step;
        cnt   <= cnt - CNT_W'(1);
        if (finish) begin
          quot_reg <= q_step;
          rem_reg  <= r_step[WIDTH-1:0];
          dz_reg   <= 1'b0;
        end
      end
    end
  end

  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dz_reg;
  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random).
module tb_seq_restoring_divider;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   failed;
  int   done_cnt4;
  int   done_cnt8;

  typedef struct {
    int q;
    int r;
    bit dz;
    int acc;
    int lat;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];

  seq_restoring_divider_if #(.WIDTH(4)) if4 ();
  seq_restoring_divider_if #(.WIDTH(8)) if8 ();

  seq_restoring_divider #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
  seq_restoring_divider #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    tests++;
    assert (!(if4.busy === 1'b1 && if4.done === 1'b1)) else begin
      failed++; $error("FAIL busy_done_w4 observed busy=%b done=%b expected not both", if4.busy, if4.done);
    end
    if (if4.done === 1'b1) begin
      done_cnt4++;
      tests++;
      assert (sb4.size() > 0) else begin
        failed++; $error("FAIL unexpected_done_w4 observed done=1 expected no pulse (q=%0d r=%0d)", if4.quotient, if4.remainder);
      end
      if (sb4.size() > 0) begin
        e = sb4.pop_front();
        tests++;
        assert (if4.quotient === 4'(e.q)) else begin
          failed++; $error("FAIL quotient_w4 observed %0d expected %0d", if4.quotient, e.q);
        end
        tests++;
        assert (if4.remainder === 4'(e.r)) else begin
          failed++; $error("FAIL remainder_w4 observed %0d expected %0d", if4.remainder, e.r);
        end
        tests++;
        assert (if4.div_by_zero === e.dz) else begin
          failed++; $error("FAIL dz_w4 observed %b expected %b", if4.div_by_zero, e.dz);
        end
        tests++;
        assert ((cyc - e.acc) == e.lat) else begin
          failed++; $error("FAIL latency_w4 observed %0d expected %0d", cyc - e.acc, e.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if8.done === 1'b1) begin
      done_cnt8++;
      tests++;
      assert (sb8.size() > 0) else begin
        failed++; $error("FAIL unexpected_done_w8 observed done=1 expected no pulse");
      end
      if (sb8.size() > 0) begin
        e = sb8.pop_front();
        tests++;
        assert (if8.quotient === 8'(e.q) && if8.remainder === 8'(e.r) && if8.div_by_zero === e.dz) else begin
          failed++; $error("FAIL result_w8 observed q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                           if8.quotient, if8.remainder, if8.div_by_zero, e.q, e.r, e.dz);
        end
        tests++;
        assert ((cyc - e.acc) == e.lat) else begin
          failed++; $error("FAIL latency_w8 observed %0d expected %0d", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic issue4(input int dvd, input int dvs);
    exp_t e;
    if4.start    = 1'b1;
    if4.dividend = 4'(dvd);
    if4.divisor  = 4'(dvs);
    @(negedge clk);
    if4.start = 1'b0;
    e.q   = (dvs == 0) ? 15 : dvd / dvs;
    e.r   = (dvs == 0) ? dvd : dvd % dvs;
    e.dz  = (dvs == 0);
    e.acc = cyc;
    e.lat = (dvs == 0) ? 1 : 4;
    sb4.push_back(e);
    tests++;
    assert (if4.busy === 1'b1) else begin
      failed++; $error("FAIL accept_w4 %0d/%0d observed busy=%b expected 1", dvd, dvs, if4.busy);
    end
  endtask

  task automatic wait_done4();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (if4.done === 1'b1) seen = 1'b1;
    end
    tests++;
    assert (seen) else begin
      failed++; $error("FAIL timeout_w4 observed no done expected done within 40 cycles");
    end
  endtask

  task automatic issue8(input int dvd, input int dvs);
    exp_t e;
    if8.start    = 1'b1;
    if8.dividend = 8'(dvd);
    if8.divisor  = 8'(dvs);
    @(negedge clk);
    if8.start = 1'b0;
    e.q   = (dvs == 0) ? 255 : dvd / dvs;
    e.r   = (dvs == 0) ? dvd : dvd % dvs;
    e.dz  = (dvs == 0);
    e.acc = cyc;
    e.lat = (dvs == 0) ? 1 : 8;
    sb8.push_back(e);
  endtask

  task automatic wait_done8();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (if8.done === 1'b1) seen = 1'b1;
    end
    tests++;
    assert (seen) else begin
      failed++; $error("FAIL timeout_w8 observed no done expected done within 40 cycles");
    end
  endtask

  task automatic check_zero4(input string tag);
    tests++;
    assert (if4.quotient === 4'd0 && if4.remainder === 4'd0 && if4.busy === 1'b0 &&
            if4.done === 1'b0 && if4.div_by_zero === 1'b0) else begin
      failed++; $error("FAIL %s observed q=%0d r=%0d busy=%b done=%b dz=%b expected all 0", tag,
                       if4.quotient, if4.remainder, if4.busy, if4.done, if4.div_by_zero);
    end
  endtask

  initial begin
    int dc0;
    int a;
    int b;
    cyc = 0; tests = 0; failed = 0; done_cnt4 = 0; done_cnt8 = 0;
    reset = 1'b1;
    if4.start = 1'b0; if4.dividend = '0; if4.divisor = '0;
    if8.start = 1'b0; if8.dividend = '0; if8.divisor = '0;
    repeat (3) @(negedge clk);
    check_zero4("reset_state");
    reset = 1'b0;
    @(negedge clk);

    issue4(13, 3);
    wait_done4();

    issue4(15, 1);  wait_done4();
    issue4(2, 7);   wait_done4();
    issue4(0, 5);   wait_done4();
    issue4(15, 15); wait_done4();

    issue4(9, 0);   wait_done4();
    issue4(6, 2);   wait_done4();
    repeat (2) @(negedge clk);

    // second start during CALC must be ignored
    dc0 = done_cnt4;
    issue4(12, 5);
    @(negedge clk);
    if4.start = 1'b1; if4.dividend = 4'd1; if4.divisor = 4'd1;
    @(negedge clk);
    if4.start = 1'b0;
    wait_done4();
    repeat (4) @(negedge clk);
    tests++;
    assert (done_cnt4 - dc0 == 1) else begin
      failed++; $error("FAIL single_done observed %0d pulses expected 1", done_cnt4 - dc0);
    end

    // reset mid-operation abandons the division
    dc0 = done_cnt4;
    issue4(14, 3);
    @(negedge clk);
    reset = 1'b1;
    sb4.delete();
    @(negedge clk);
    check_zero4("reset_midop");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    assert (done_cnt4 == dc0) else begin
      failed++; $error("FAIL no_done_after_reset observed %0d pulses expected 0", done_cnt4 - dc0);
    end
    issue4(14, 3);
    wait_done4();

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        issue4(i, j);
        wait_done4();
      end
    end

    for (int k = 0; k < 1000; k++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
      issue8(a, b);
      wait_done8();
    end

    repeat (5) @(negedge clk);
    tests++;
    assert (sb4.size() == 0 && sb8.size() == 0) else begin
      failed++; $error("FAIL scoreboard_drain observed %0d/%0d pending expected 0/0", sb4.size(), sb8.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
